// File: rtl/lift_pkg.sv
// Shared constants and types for the lift call-button panel.
package lift_pkg;
    localparam int NUM_FLOORS = 8;
    localparam int FLOOR_W    = $clog2(NUM_FLOORS);

    typedef logic [FLOOR_W-1:0] floor_t;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } panel_state_t;
endpackage

// File: rtl/lift_btn_debounce.sv
// One button: 2-flop synchroniser, stable-level debounce counter, registered press pulse.
module lift_btn_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYC)) begin
                // Level has differed long enough: accept it; only a rising edge is a press.
                r_level <= r_sync2;
                r_cnt   <= '0;
                r_press <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;
endmodule

// File: rtl/lift_call_panel.sv
// Call-button front end: debounced presses latch lamps, offered one at a time over valid/ready.
// Optional build macro LIFT_CALL_CANCEL_EN: a second press on a pending, unsent floor cancels it.
module lift_call_panel #(
    parameter int NUM_FLOORS   = 8,
    parameter int FLOOR_W      = 3,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] btn,
    input  logic                  emergency_stop,
    output logic [FLOOR_W-1:0]    req_floor,
    output logic                  req_valid,
    input  logic                  req_ready,
    input  logic [FLOOR_W-1:0]    served_floor,
    input  logic                  served_valid,
    output logic [NUM_FLOORS-1:0] pending,
    output logic [NUM_FLOORS-1:0] sent,
    output logic                  o_dbg_state
);
    import lift_pkg::*;

    // Handshake: req_floor/req_valid stay stable from assertion until req_valid & req_ready
    // at a rising edge; the only exception is a serve or cancel of the offered floor.

    logic [NUM_FLOORS-1:0] w_press;
    logic [NUM_FLOORS-1:0] w_serve_hit;
    logic [NUM_FLOORS-1:0] w_cancel;
    logic [NUM_FLOORS-1:0] w_clear;
    logic [NUM_FLOORS-1:0] w_elig;
    logic [NUM_FLOORS-1:0] r_pending;
    logic [NUM_FLOORS-1:0] r_sent;
    logic [FLOOR_W-1:0]    r_req_floor;
    logic [FLOOR_W-1:0]    r_ptr;
    logic [FLOOR_W-1:0]    w_pick;
    logic                  r_req_valid;
    logic                  w_found;
    logic                  w_hs;
    logic                  w_withdraw;
    panel_state_t          r_state;

    for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_btn
        lift_btn_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .i_btn  (btn[g]),
            .o_press(w_press[g])
        );
    end

    always_comb begin
        for (int f = 0; f < NUM_FLOORS; f++) begin
            w_serve_hit[f] = served_valid && (int'(served_floor) == f);
        end
`ifdef LIFT_CALL_CANCEL_EN
        w_cancel = w_press & r_pending & ~r_sent;
`else
        w_cancel = '0;
`endif
        w_clear = w_serve_hit | w_cancel;
        // A floor being cleared this cycle is never picked, so no offer outlives its call.
        w_elig     = r_pending & ~r_sent & ~w_clear;
        w_hs       = (r_state == OFFER) && r_req_valid && req_ready;
        w_withdraw = (r_state == OFFER) && w_clear[r_req_floor];
    end

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (!w_found && w_elig[(int'(r_ptr) + i) % NUM_FLOORS]) begin
                w_found = 1'b1;
                w_pick  = FLOOR_W'((int'(r_ptr) + i) % NUM_FLOORS);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
            r_sent    <= '0;
        end else begin
            for (int f = 0; f < NUM_FLOORS; f++) begin
                if (w_clear[f]) begin
                    r_pending[f] <= 1'b0;
                    r_sent[f]    <= 1'b0;
                end else begin
                    if (w_press[f] && !r_sent[f]) begin
                        r_pending[f] <= 1'b1;
                    end
                    if (w_hs && (r_req_floor == FLOOR_W'(f))) begin
                        r_sent[f] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_req_floor <= '0;
            r_req_valid <= 1'b0;
            r_ptr       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_req_valid <= 1'b0;
                    if (w_found && !emergency_stop) begin
                        r_req_floor <= w_pick;
                        r_req_valid <= 1'b1;
                        r_state     <= OFFER;
                    end
                end
                OFFER: begin
                    if (w_hs) begin
                        r_ptr       <= (r_req_floor == FLOOR_W'(NUM_FLOORS - 1)) ? '0 : r_req_floor + 1'b1;
                        r_req_valid <= 1'b0;
                        r_state     <= IDLE;
                    end else if (w_withdraw) begin
                        r_req_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_req_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign req_floor   = r_req_floor;
    assign req_valid   = r_req_valid;
    assign pending     = r_pending;
    assign sent        = r_sent;
    assign o_dbg_state = (r_state == OFFER);
endmodule

// File: tb/tb_lift_call_panel.sv
// Self-checking bench for lift_call_panel: debounce vector table plus hand-written corner sequences.
module tb_lift_call_panel;
    import lift_pkg::*;

    localparam int DEB = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [7:0]   btn = '0;
    logic         emergency_stop = 1'b0;
    logic [2:0]   req_floor;
    logic         req_valid;
    logic         req_ready = 1'b0;
    logic [2:0]   served_floor = '0;
    logic         served_valid = 1'b0;
    logic [7:0]   pending;
    logic [7:0]   sent;
    logic         dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [FLOOR_W-1:0] exp_q[$];

    typedef struct {
        logic [7:0] mask;
        int         hold;
        logic [7:0] exp_pending;
    } vec_t;
    vec_t vecs[6];

    lift_call_panel #(
        .NUM_FLOORS  (8),
        .FLOOR_W     (3),
        .DEBOUNCE_CYC(DEB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn           (btn),
        .emergency_stop(emergency_stop),
        .req_floor     (req_floor),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .served_floor  (served_floor),
        .served_valid  (served_valid),
        .pending       (pending),
        .sent          (sent),
        .o_dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted offer must match the next expected floor.
    always @(negedge clk) begin
        if (reset && req_valid && req_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_handshake: got floor %0d expected none", req_floor);
            end else begin
                chk("handshake_floor", 32'(req_floor), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] mask, input int hold);
        btn = btn | mask;
        tick(hold);
        btn = btn & ~mask;
    endtask

    task automatic serve(input int f);
        served_floor = 3'(f);
        served_valid = 1'b1;
        tick(1);
        served_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!req_valid && k < 40) begin
            tick(1);
            k++;
        end
        if (!req_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got req_valid 0 expected 1 within 40 cycles", name);
        end
    endtask

    task automatic clean_all();
        req_ready = 1'b0;
        for (int f = 0; f < 8; f++) serve(f);
        tick(DEB + 4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] bnc;
        vecs[0] = '{8'h20, 1,  8'h00};
        vecs[1] = '{8'h20, 3,  8'h00};
        vecs[2] = '{8'h08, 6,  8'h08};
        vecs[3] = '{8'h21, 6,  8'h21};
        vecs[4] = '{8'h80, 2,  8'h00};
        vecs[5] = '{8'h0a, 12, 8'h0a};

        // Reset state
        tick(3);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_sent", 32'(sent), 32'h0);
        chk("rst_valid", 32'(req_valid), 32'h0);
        chk("rst_floor", 32'(req_floor), 32'h0);
        chk("rst_state", 32'(dbg_state), 32'h0);
        reset = 1'b1;
        tick(2);

        // Clean press of floor 3: exact latency, handshake, serve; button stays held
        req_ready = 1'b1;
        exp_q.push_back(3'd3);
        btn[3] = 1'b1;
        @(posedge clk);
        #1;
        tick(6);
        chk("lat_pending_e6", 32'(pending[3]), 32'h0);
        tick(1);
        chk("lat_pending_e7", 32'(pending[3]), 32'h1);
        chk("lat_valid_e7", 32'(req_valid), 32'h0);
        tick(1);
        chk("lat_valid_e8", 32'(req_valid), 32'h1);
        chk("lat_floor_e8", 32'(req_floor), 32'h3);
        tick(1);
        chk("lat_sent_e9", 32'(sent[3]), 32'h1);
        chk("lat_valid_e9", 32'(req_valid), 32'h0);
        req_ready = 1'b0;
        serve(3);
        chk("serve_pending", 32'(pending[3]), 32'h0);
        chk("serve_sent", 32'(sent[3]), 32'h0);
        tick(12);
        chk("held_no_repress", 32'(pending), 32'h0);
        btn[3] = 1'b0;
        tick(DEB + 6);

        // Debounce vector table
        for (int v = 0; v < 6; v++) begin
            press(vecs[v].mask, vecs[v].hold);
            tick(DEB + 8);
            chk("vec_pending", 32'(pending), 32'(vecs[v].exp_pending));
            chk("vec_sent", 32'(sent), 32'h0);
            clean_all();
        end

        // Bouncing floor 5, never stable long enough
        bnc = 10'b0111011010;
        for (int i = 0; i < 10; i++) begin
            btn[5] = bnc[i];
            tick(1);
        end
        btn[5] = 1'b0;
        tick(12);
        chk("bounce_pending", 32'(pending), 32'h0);

        // Round robin: move ptr to 5 via floor 4, then pending 1,4,6
        req_ready = 1'b1;
        exp_q.push_back(3'd4);
        press(8'h10, 6);
        wait_valid("rr_setup_valid");
        tick(2);
        req_ready = 1'b0;
        serve(4);
        tick(DEB + 4);
        chk("rr_setup_clear", 32'(pending), 32'h0);
        press(8'h52, 6);
        wait_valid("rr_first_valid");
        chk("rr_first_floor", 32'(req_floor), 32'h6);
        exp_q.push_back(3'd6);
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd4);
        req_ready = 1'b1;
        tick(1);
        chk("rr_gap1", 32'(req_valid), 32'h0);
        tick(1);
        chk("rr_valid2", 32'(req_valid), 32'h1);
        chk("rr_floor2", 32'(req_floor), 32'h1);
        tick(1);
        chk("rr_gap2", 32'(req_valid), 32'h0);
        tick(1);
        chk("rr_valid3", 32'(req_valid), 32'h1);
        chk("rr_floor3", 32'(req_floor), 32'h4);
        tick(1);
        chk("rr_gap3", 32'(req_valid), 32'h0);
        chk("rr_sent", 32'(sent), 32'h52);
        clean_all();

        // Emergency stop blocks offers but not latching
        emergency_stop = 1'b1;
        press(8'h04, 6);
        tick(8);
        chk("estop_valid", 32'(req_valid), 32'h0);
        chk("estop_pending", 32'(pending), 32'h04);
        emergency_stop = 1'b0;
        tick(1);
        chk("estop_release_valid", 32'(req_valid), 32'h1);
        chk("estop_release_floor", 32'(req_floor), 32'h2);
        clean_all();

        // Serve of the offered floor withdraws the offer
        press(8'h80, 6);
        wait_valid("wd_valid");
        chk("wd_floor", 32'(req_floor), 32'h7);
        serve(7);
        chk("wd_valid_drop", 32'(req_valid), 32'h0);
        chk("wd_sent", 32'(sent[7]), 32'h0);
        chk("wd_pending", 32'(pending[7]), 32'h0);
        tick(1);
        chk("wd_stays_idle", 32'(req_valid), 32'h0);

        // Handshake and serve of the same floor in one cycle
        press(8'h08, 6);
        wait_valid("hs_serve_valid");
        exp_q.push_back(3'd3);
        req_ready = 1'b1;
        served_floor = 3'd3;
        served_valid = 1'b1;
        tick(1);
        served_valid = 1'b0;
        req_ready = 1'b0;
        chk("hs_serve_valid_drop", 32'(req_valid), 32'h0);
        chk("hs_serve_sent", 32'(sent), 32'h0);
        chk("hs_serve_pending", 32'(pending), 32'h0);
        tick(DEB + 4);

        // Second press of an unsent pending floor
        press(8'h04, 6);
        tick(DEB + 4);
        wait_valid("cancel_first_valid");
        chk("cancel_pending_before", 32'(pending), 32'h04);
        press(8'h04, 6);
        tick(DEB + 4);
`ifdef LIFT_CALL_CANCEL_EN
        chk("cancel_pending_after", 32'(pending), 32'h00);
        chk("cancel_valid_after", 32'(req_valid), 32'h0);
`else
        chk("repress_pending_after", 32'(pending), 32'h04);
        chk("repress_valid_after", 32'(req_valid), 32'h1);
        chk("repress_floor_after", 32'(req_floor), 32'h2);
`endif
        clean_all();

        // Asynchronous reset in the middle of an offer
        press(8'h10, 6);
        wait_valid("areset_valid");
        tick(DEB + 4);
        chk("areset_pre_pending", 32'(pending), 32'h10);
        chk("areset_pre_valid", 32'(req_valid), 32'h1);
        #3;
        reset = 1'b0;
        #1;
        chk("areset_pending", 32'(pending), 32'h0);
        chk("areset_sent", 32'(sent), 32'h0);
        chk("areset_valid", 32'(req_valid), 32'h0);
        chk("areset_floor", 32'(req_floor), 32'h0);
        chk("areset_state", 32'(dbg_state), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick(15);
        chk("areset_post_valid", 32'(req_valid), 32'h0);
        chk("areset_post_pending", 32'(pending), 32'h0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
